// File: rtl/rx_snapshot_core.sv
// rx_snapshot_core: truncates each 16-bit ADC lane to its OUT_WIDTH MSBs and,
// once armed, records a triggered snapshot (pre-trigger history plus
// post-trigger tail) in a circular buffer that is read back oldest-first.
module rx_snapshot_core #(
    parameter  int NUMBER_OF_LINE = 8,
    parameter  int OUT_WIDTH      = 15,
    parameter  int DEPTH          = 256,
    localparam int AW             = $clog2(DEPTH),
    localparam int LW             = (NUMBER_OF_LINE > 1) ? $clog2(NUMBER_OF_LINE) : 1,
    localparam int DW             = OUT_WIDTH * NUMBER_OF_LINE
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [16*NUMBER_OF_LINE-1:0]  adc_data,
    input  logic                          adc_valid,
    output logic [DW-1:0]                 rx_data,
    output logic                          rx_valid,
    input  logic                          arm,
    input  logic                          abort,
    input  logic                          trig_in,
    input  logic [1:0]                    trig_mode,
    input  logic [LW-1:0]                 trig_lane,
    input  logic [OUT_WIDTH-1:0]          threshold,
    input  logic [AW-1:0]                 pretrig,
    input  logic                          rd_en,
    input  logic [AW-1:0]                 rd_addr,
    output logic [DW-1:0]                 rd_data,
    output logic                          rd_valid,
    output logic [1:0]                    state,
    output logic                          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_LEVEL = 2'd1;
    localparam logic [1:0] MODE_EITHER = 2'd2;

    // Most negative and most positive lane values; the former has no positive
    // counterpart, so its magnitude is clamped to the latter.
    localparam logic [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    state_t               state_q, state_d;
    logic [DW-1:0]        rx_next;
    logic                 trig_q;
    logic [AW-1:0]        wr_ptr, trig_ptr, pretrig_q, fill_cnt, post_cnt;
    logic [AW-1:0]        post_target, start_ptr;
    logic [OUT_WIDTH-1:0] lane_sel, lane_mag;
    logic                 ext_edge, level_hit, trig_cond, qualified;
    logic                 wr_en, trig_fire, load_arm;
    logic [DW-1:0]        mem [DEPTH];

    // The discarded LSBs of every lane are intentionally unused.
    logic unused_adc_bits;
    assign unused_adc_bits = ^adc_data;

    assign state       = state_q;
    assign done        = (state_q == DONE);
    // Words still owed after the triggering word, and the oldest word kept.
    assign post_target = AW'(DEPTH - 1) - pretrig_q;
    assign start_ptr   = trig_ptr - pretrig_q;

    // Keep the top OUT_WIDTH bits of each 16-bit lane.
    // NOTE: every variable assigned in an always_comb gets a value on every path
    // (here a default first), otherwise synthesis infers a latch.
    always_comb begin
        rx_next = '0;
        for (int k = 0; k < NUMBER_OF_LINE; k++) begin
            rx_next[k*OUT_WIDTH +: OUT_WIDTH] = adc_data[16*k + 16 - OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // Register the truncated lanes and their qualifier in every state.
    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together from pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            rx_data  <= rx_next;
            rx_valid <= adc_valid;
            trig_q   <= trig_in;
        end
    end

    // Trigger sources: trig_in rising edge, and lane magnitude against threshold.
    always_comb begin
        lane_sel = rx_data[OUT_WIDTH-1:0];
        for (int k = 1; k < NUMBER_OF_LINE; k++) begin
            if (trig_lane == LW'(k)) begin
                lane_sel = rx_data[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
        if (!lane_sel[OUT_WIDTH-1]) begin
            lane_mag = lane_sel;
        end else if (lane_sel == MIN_VAL) begin
            lane_mag = MAX_VAL;
        end else begin
            lane_mag = '0 - lane_sel;
        end
        ext_edge  = trig_in & ~trig_q;
        level_hit = rx_valid && (lane_mag >= threshold);
        case (trig_mode)
            MODE_EXT:    trig_cond = ext_edge;
            MODE_LEVEL:  trig_cond = level_hit;
            MODE_EITHER: trig_cond = ext_edge | level_hit;
            default:     trig_cond = 1'b1;
        endcase
        // Triggers before enough history has been gathered are dropped.
        qualified = (fill_cnt >= pretrig_q);
    end

    // Next-state logic and the per-cycle strobes that drive the datapath.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        trig_fire = 1'b0;
        load_arm  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = ARMED;
                    load_arm = 1'b1;
                end
            end
            ARMED: begin
                wr_en = rx_valid;
                if (qualified && trig_cond) begin
                    state_d   = POST;
                    trig_fire = 1'b1;
                end
            end
            POST: begin
                if (post_cnt == post_target) begin
                    state_d = DONE;
                end else begin
                    wr_en = rx_valid;
                    if (rx_valid && (post_cnt == post_target - AW'(1))) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                if (arm) begin
                    state_d  = ARMED;
                    load_arm = 1'b1;
                end
            end
        endcase
        if (abort) begin
            state_d   = IDLE;
            wr_en     = 1'b0;
            trig_fire = 1'b0;
            load_arm  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write pointer, fill/post counters, latched pretrig and trigger address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            trig_ptr  <= '0;
            pretrig_q <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load_arm) begin
                fill_cnt  <= '0;
                pretrig_q <= pretrig;
            end else if (wr_en && state_q == ARMED && fill_cnt < pretrig_q) begin
                fill_cnt <= fill_cnt + AW'(1);
            end
            if (trig_fire) begin
                trig_ptr <= wr_ptr;
                post_cnt <= '0;
            end else if (wr_en && state_q == POST) begin
                post_cnt <= post_cnt + AW'(1);
            end
        end
    end

    // Capture buffer write port.
    // NOTE: the storage array has no reset; clearing it would cost a write per
    // entry and every readable word is rewritten by a capture before DONE.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Readout, relative to the oldest kept word, only once the capture is done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (state_q == DONE && rd_en) begin
            rd_data  <= mem[start_ptr + rd_addr];
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule
